// File: rtl/ttt_auto_player.sv
// ttt_auto_player: automated tic-tac-toe opponent.
// Picks a target cell, walks the board cursor there and presses centre.
module ttt_auto_player #(
  parameter bit ME_P2        = 1'b0,
  parameter int PULSE_CYCLES = 10,
  parameter int GAP_CYCLES   = 10,
  parameter int ACK_TIMEOUT  = 64,
  parameter int MAX_STEPS    = 8
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] P1,
  input  logic [8:0] P2,
  input  logic [3:0] I,
  input  logic       PlayerMoved,
  input  logic       P1Won,
  input  logic       P2Won,
  output logic       BtnL,
  output logic       BtnR,
  output logic       BtnU,
  output logic       BtnD,
  output logic       BtnC,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] target
);

  localparam int M1 =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CMAX = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
  localparam int CW = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] PLD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GLD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ALD = CW'(ACK_TIMEOUT - 1);

  // Three 4-bit cell numbers per line, line 0 in the low bits.
  localparam logic [95:0] LINES = {
    12'h642, 12'h840, 12'h852, 12'h741,
    12'h630, 12'h876, 12'h543, 12'h210
  };

  typedef enum logic [3:0] {
    IDLE, PICK, CMP, PULSE, GAP,
    PLACE, PGAP, WAIT_ACK, DONE, FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    dir_q, dir_d;
  logic [3:0]    tgt_q, tgt_d;
  logic [4:0]    btn_q, btn_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [8:0] own, opp, free;
  logic [8:0] win, blk;
  logic [3:0] fw, fb, fc, fe, pick;
  logic [3:0] rci, rct;

  function automatic logic [8:0] threats(
    input logic [8:0] m,
    input logic [8:0] f
  );
    logic [8:0] r;
    logic [3:0] a, b, c;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      a = LINES[l*12 +: 4];
      b = LINES[l*12+4 +: 4];
      c = LINES[l*12+8 +: 4];
      r[a] = r[a] | (f[a] & m[b] & m[c]);
      r[b] = r[b] | (f[b] & m[a] & m[c]);
      r[c] = r[c] | (f[c] & m[a] & m[b]);
    end
    return r;
  endfunction

  function automatic logic [3:0] first(input logic [8:0] v);
    logic [3:0] r;
    r = 4'hF;
    for (int n = 8; n >= 0; n--)
      if (v[4'(n)]) r = 4'(n);
    return r;
  endfunction

  // {row, col} of a cell; off-board indices map to 0.
  function automatic logic [3:0] rc(input logic [3:0] c);
    logic [3:0] r;
    unique case (c)
      4'd0:    r = {2'd0, 2'd0};
      4'd1:    r = {2'd0, 2'd1};
      4'd2:    r = {2'd0, 2'd2};
      4'd3:    r = {2'd1, 2'd0};
      4'd4:    r = {2'd1, 2'd1};
      4'd5:    r = {2'd1, 2'd2};
      4'd6:    r = {2'd2, 2'd0};
      4'd7:    r = {2'd2, 2'd1};
      4'd8:    r = {2'd2, 2'd2};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  assign own  = ME_P2 ? P2 : P1;
  assign opp  = ME_P2 ? P1 : P2;
  assign free = ~(P1 | P2);

  always_comb begin
    win = threats(own, free);
    blk = threats(opp, free);
    fw  = first(win);
    fb  = first(blk);
    fc  = first(free & 9'h145);
    fe  = first(free & 9'h0AA);
    priority case (1'b1)
      fw != 4'hF: pick = fw;
      fb != 4'hF: pick = fb;
      free[4]:    pick = 4'd4;
      fc != 4'hF: pick = fc;
      default:    pick = fe;
    endcase
  end

  assign rci = rc(I);
  assign rct = rc(tgt_q);

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      dir_q   <= '0;
      tgt_q   <= 4'hF;
      btn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: if (start) state_d = PICK;
      PICK: begin
        if (P1Won | P2Won || free == '0) begin
          tgt_d   = 4'hF;
          state_d = FAULT;
        end else begin
          tgt_d   = pick;
          step_d  = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        // dir bits are {L, R, U, D}; column is fixed first
        dir_d = '0;
        if (rci[1:0] < rct[1:0])      dir_d = 4'b0100;
        else if (rci[1:0] > rct[1:0]) dir_d = 4'b1000;
        else if (rci[3:2] < rct[3:2]) dir_d = 4'b0001;
        else if (rci[3:2] > rct[3:2]) dir_d = 4'b0010;
        if (I > 4'd8) begin
          state_d = FAULT;
        end else if (dir_d == '0) begin
          cnt_d   = PLD;
          state_d = PLACE;
        end else if (step_q == 4'(MAX_STEPS)) begin
          state_d = FAULT;
        end else begin
          step_d  = step_q + 4'd1;
          cnt_d   = PLD;
          state_d = PULSE;
        end
      end
      PULSE, PLACE: begin
        if (cnt_q == '0) begin
          cnt_d   = GLD;
          state_d = (state_q == PULSE) ? GAP : PGAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = CMP;
        else cnt_d = cnt_q - CW'(1);
      end
      PGAP: begin
        if (cnt_q == '0) begin
          cnt_d   = ALD;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_ACK: begin
        if (PlayerMoved) state_d = DONE;
        else if (cnt_q == '0) state_d = FAULT;
        else cnt_d = cnt_q - CW'(1);
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    btn_d  = '0;
    if (state_d == PULSE) btn_d[4:1] = dir_d;
    if (state_d == PLACE) btn_d[0] = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state_d == FAULT);
  end

  assign BtnL   = btn_q[4];
  assign BtnR   = btn_q[3];
  assign BtnU   = btn_q[2];
  assign BtnD   = btn_q[1];
  assign BtnC   = btn_q[0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = err_q;
  assign target = tgt_q;

endmodule

// File: tb/tb_ttt_auto_player.sv
// tb_ttt_auto_player: timeline model of each move plus a board model
// that follows the cursor buttons and acknowledges placements.
module tb_ttt_auto_player;

  localparam int P = 10;
  localparam int G = 10;
  localparam int A = 64;
  localparam int M = 8;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [8:0] P1, P2;
  logic [3:0] I;
  logic       PlayerMoved;
  logic       P1Won, P2Won;
  logic       BtnL, BtnR, BtnU, BtnD, BtnC;
  logic       busy, done, error;
  logic [3:0] target;

  always #5 Clk = ~Clk;

  ttt_auto_player #(
    .ME_P2(1'b0), .PULSE_CYCLES(P), .GAP_CYCLES(G),
    .ACK_TIMEOUT(A), .MAX_STEPS(M)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .start(start),
    .P1(P1), .P2(P2), .I(I), .PlayerMoved(PlayerMoved),
    .P1Won(P1Won), .P2Won(P2Won),
    .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD),
    .BtnC(BtnC), .busy(busy), .done(done), .error(error),
    .target(target)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int CO [4] = '{0, 2, 6, 8};
  int ED [4] = '{1, 3, 5, 7};

  logic [11:0] exp_q [$];
  logic [3:0]  last_tgt;

  bit follow, ack_en;
  int ack_d;
  int cnt_l, cnt_r, cnt_u, cnt_d, cnt_c, n_done, n_err;
  int c_rise, c_fall, err_cyc, start_cyc;

  task automatic chk(input string nm, input int g, input int e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, g, e);
    end
  endtask

  // Placing a piece at c would leave a whole line of m through c.
  function automatic bit completes(input logic [8:0] m, input int c);
    logic [8:0] t;
    t = m;
    t[c] = 1'b1;
    for (int l = 0; l < 8; l++)
      if ((LN[l][0] == c || LN[l][1] == c || LN[l][2] == c) &&
          t[LN[l][0]] && t[LN[l][1]] && t[LN[l][2]])
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_pick(input logic [8:0] own,
                                  input logic [8:0] opp);
    logic [8:0] fr;
    fr = ~(own | opp);
    for (int c = 0; c < 9; c++)
      if (fr[c] && completes(own, c)) return c;
    for (int c = 0; c < 9; c++)
      if (fr[c] && completes(opp, c)) return c;
    if (fr[4]) return 4;
    for (int k = 0; k < 4; k++) if (fr[CO[k]]) return CO[k];
    for (int k = 0; k < 4; k++) if (fr[ED[k]]) return ED[k];
    return 15;
  endfunction

  function automatic void push(input int n, input logic [4:0] b,
                               input logic bz, input logic dn,
                               input logic er, input logic [3:0] t);
    for (int k = 0; k < n; k++) exp_q.push_back({b, bz, dn, er, t});
  endfunction

  // Expected per-cycle outputs {L,R,U,D,C,busy,done,error,target}.
  task automatic plan(input logic [8:0] p1, input logic [8:0] p2,
                      input logic won, input int i0, input bit fol,
                      input bit aen, input int ad);
    int t, cur, nxt, steps;
    logic [4:0] b;
    push(1, 5'b0, 1, 0, 0, last_tgt);
    if (won || (p1 | p2) == 9'h1FF) begin
      last_tgt = 4'hF;
      push(1, 5'b0, 1, 0, 1, last_tgt);
      push(2, 5'b0, 0, 0, 0, last_tgt);
      return;
    end
    t = ref_pick(p1, p2);
    last_tgt = 4'(t);
    cur = i0;
    steps = 0;
    forever begin
      push(1, 5'b0, 1, 0, 0, last_tgt);
      if (cur > 8 || (cur != t && steps == M)) begin
        push(1, 5'b0, 1, 0, 1, last_tgt);
        break;
      end
      if (cur == t) begin
        push(P, 5'b00001, 1, 0, 0, last_tgt);
        push(G, 5'b0, 1, 0, 0, last_tgt);
        if (aen && ad >= G && ad <= G + A - 1) begin
          push(ad - G + 1, 5'b0, 1, 0, 0, last_tgt);
          push(1, 5'b0, 1, 1, 0, last_tgt);
        end else begin
          push(A, 5'b0, 1, 0, 0, last_tgt);
          push(1, 5'b0, 1, 0, 1, last_tgt);
        end
        break;
      end
      if (cur % 3 < t % 3) begin b = 5'b01000; nxt = cur + 1; end
      else if (cur % 3 > t % 3) begin b = 5'b10000; nxt = cur - 1; end
      else if (cur / 3 < t / 3) begin b = 5'b00010; nxt = cur + 3; end
      else begin b = 5'b00100; nxt = cur - 3; end
      steps++;
      push(P, b, 1, 0, 0, last_tgt);
      push(G, 5'b0, 1, 0, 0, last_tgt);
      if (fol) cur = nxt;
    end
    push(2, 5'b0, 0, 0, 0, last_tgt);
  endtask

  wire [11:0] got = {BtnL, BtnR, BtnU, BtnD, BtnC,
                     busy, done, error, target};

  always @(negedge Clk) begin
    logic [11:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
  end

  // Board: cursor follows button rises; one-cycle ack ack_d after BtnC falls.
  initial begin
    logic [4:0] pb;
    logic pd, pe;
    int fc;
    pb = '0; pd = 1'b0; pe = 1'b0; fc = -1;
    PlayerMoved = 1'b0;
    forever begin
      @(negedge Clk);
      if (BtnL && !pb[4]) begin cnt_l++; if (follow) I = I - 4'd1; end
      if (BtnR && !pb[3]) begin cnt_r++; if (follow) I = I + 4'd1; end
      if (BtnU && !pb[2]) begin cnt_u++; if (follow) I = I - 4'd3; end
      if (BtnD && !pb[1]) begin cnt_d++; if (follow) I = I + 4'd3; end
      if (BtnC && !pb[0]) begin cnt_c++; c_rise = cyc; end
      if (!BtnC && pb[0]) begin fc = 0; c_fall = cyc; end
      else if (fc >= 0) fc++;
      PlayerMoved = ack_en && (fc == ack_d);
      if (done && !pd) n_done++;
      if (error && !pe) begin n_err++; err_cyc = cyc; end
      pb = {BtnL, BtnR, BtnU, BtnD, BtnC};
      pd = done;
      pe = error;
    end
  end

  task automatic run_move(input logic [8:0] p1, input logic [8:0] p2,
                          input logic w1, input logic w2,
                          input logic [3:0] i0, input bit fol,
                          input bit aen, input int ad);
    int n;
    @(negedge Clk);
    P1 = p1; P2 = p2; P1Won = w1; P2Won = w2; I = i0;
    follow = fol; ack_en = aen; ack_d = ad;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge Clk);
    cnt_l = 0; cnt_r = 0; cnt_u = 0; cnt_d = 0; cnt_c = 0;
    n_done = 0; n_err = 0;
    plan(p1, p2, w1 | w2, int'(i0), fol, aen, ad);
    #1 start = 1'b0;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge Clk);
      n++;
      if (n == 2) begin
        // board changes and a stray start mid-move must not matter
        start = 1'b1;
        P1 = 9'($urandom);
        P2 = 9'($urandom);
        P1Won = 1'($urandom_range(0, 1));
      end
      if (n == 3) start = 1'b0;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL timeout left=%0d exp=0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  initial begin
    logic [8:0] a, b;
    bit seen;
    reset_n = 1'b0; start = 1'b1;
    P1 = '0; P2 = '0; I = '0; P1Won = 1'b0; P2Won = 1'b0;
    follow = 1'b1; ack_en = 1'b0; ack_d = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_btn", int'({BtnL, BtnR, BtnU, BtnD, BtnC}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_target", int'(target), 15);
    chk("rst_flags", int'({done, error}), 0);
    reset_n = 1'b1;
    start = 1'b0;
    last_tgt = 4'hF;

    run_move(9'h003, 9'h018, 0, 0, 4'd4, 1, 1, G + 3);
    chk("win_target", int'(target), 2);
    chk("win_r", cnt_r, 1);
    chk("win_u", cnt_u, 1);
    chk("win_ld", cnt_l + cnt_d, 0);
    chk("win_c", cnt_c, 1);
    chk("win_done", n_done, 1);

    run_move(9'h100, 9'h003, 0, 0, 4'd8, 1, 1, G);
    chk("blk_target", int'(target), 2);
    chk("blk_u", cnt_u, 2);
    chk("blk_c", cnt_c, 1);
    chk("blk_done", n_done, 1);

    run_move(9'h000, 9'h000, 0, 0, 4'd4, 1, 1, G + A - 1);
    chk("open_target", int'(target), 4);
    chk("open_c_lat", c_rise - start_cyc, 3);
    chk("open_moves", cnt_l + cnt_r + cnt_u + cnt_d, 0);
    chk("open_done", n_done, 1);

    run_move(9'h155, 9'h0AA, 0, 0, 4'd4, 1, 1, G);
    chk("full_err", n_err, 1);
    chk("full_btns", cnt_l + cnt_r + cnt_u + cnt_d + cnt_c, 0);
    chk("full_target", int'(target), 15);

    run_move(9'h000, 9'h000, 1, 0, 4'd4, 1, 1, G);
    chk("won_err", n_err, 1);
    chk("won_c", cnt_c, 0);
    chk("won_target", int'(target), 15);

    run_move(9'h000, 9'h000, 0, 0, 4'd0, 0, 1, G);
    chk("stuck_r", cnt_r, M);
    chk("stuck_err", n_err, 1);
    chk("stuck_c", cnt_c, 0);

    run_move(9'h000, 9'h000, 0, 0, 4'd4, 1, 0, 0);
    chk("noack_err", n_err, 1);
    chk("noack_lat", err_cyc - c_fall, G + A);

    run_move(9'h000, 9'h000, 0, 0, 4'd4, 1, 1, G - 1);
    chk("early_ack_err", n_err, 1);
    chk("early_ack_done", n_done, 0);

    for (int s = 0; s < 40; s++) begin
      logic [3:0] i0;
      logic w;
      a = '0;
      b = '0;
      for (int c = 0; c < 9; c++)
        case ($urandom_range(0, 2))
          1: a[c] = 1'b1;
          2: b[c] = 1'b1;
          default: ;
        endcase
      if ($urandom_range(0, 7) == 0) begin
        a = 9'($urandom);
        b = ~a;
      end
      w = ($urandom_range(0, 9) == 0);
      i0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                       : 4'($urandom_range(0, 8));
      run_move(a, b, w, 1'b0, i0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 5) != 0, $urandom_range(0, G + A + 5));
    end

    @(negedge Clk);
    P1 = '0; P2 = '0; P1Won = 1'b0; P2Won = 1'b0; I = 4'd0;
    follow = 1'b1; ack_en = 1'b0;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge Clk);
      if (BtnL | BtnR | BtnU | BtnD) seen = 1'b1;
    end
    chk("mid_pulse_seen", int'(seen), 1);
    reset_n = 1'b0;
    @(negedge Clk);
    chk("mid_rst_btn", int'({BtnL, BtnR, BtnU, BtnD, BtnC}), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_target", int'(target), 15);
    reset_n = 1'b1;
    last_tgt = 4'hF;
    repeat (2) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
